// File: rtl/exu_bp_upd_q.sv
// Branch-predictor update queue: buffers resolved-branch BHT updates and drains them to the IFU.
// Optional RV_BPUPD_STATS_EN adds update/mispredict/drop event counters.
module exu_bp_upd_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     upd_valid,
  input  logic                     upd_misp,
  input  logic                     upd_ataken,
  input  logic [1:0]               upd_hist,
  input  logic [IDX_W-1:0]         upd_index,
  output logic                     bht_wr_valid,
  input  logic                     bht_wr_ready,
  output logic [IDX_W-1:0]         bht_wr_index,
  output logic [1:0]               bht_wr_hist,
  output logic                     bht_wr_misp,
  output logic                     bht_wr_ataken,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     drop_pulse
`ifdef RV_BPUPD_STATS_EN
  ,
  output logic [31:0]              stat_upd,
  output logic [31:0]              stat_misp,
  output logic [31:0]              stat_drop
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IDX_W-1:0] r_idx  [DEPTH];
  logic [1:0]       r_hist [DEPTH];
  logic             r_misp [DEPTH];
  logic             r_at   [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic [PW-1:0] w_tail_ptr;
  logic          w_nonempty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_coal;
  logic          w_alloc;
  logic          w_drop;

  always_comb begin
    w_tail_ptr = r_wr_ptr - PW'(1);
    w_nonempty = (r_count != '0);
    w_full     = (r_count == CW'(DEPTH));
    w_push     = upd_valid & ~freeze;
    w_pop      = w_nonempty & bht_wr_ready;
    // A lone entry leaving this cycle cannot absorb the new update; it gets a fresh slot.
    w_coal     = w_push & w_nonempty & (upd_index == r_idx[w_tail_ptr])
                 & ~(w_pop & (r_count == CW'(1)));
    w_alloc    = w_push & ~w_coal & (~w_full | w_pop);
    w_drop     = w_push & w_full & ~w_pop & ~w_coal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i]  <= '0;
        r_hist[i] <= '0;
        r_misp[i] <= 1'b0;
        r_at[i]   <= 1'b0;
      end
    end else begin
      r_drop  <= w_drop;
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_coal) begin
        r_hist[w_tail_ptr] <= upd_hist;
        r_at[w_tail_ptr]   <= upd_ataken;
        r_misp[w_tail_ptr] <= r_misp[w_tail_ptr] | upd_misp;
      end else if (w_alloc) begin
        r_idx[r_wr_ptr]  <= upd_index;
        r_hist[r_wr_ptr] <= upd_hist;
        r_misp[r_wr_ptr] <= upd_misp;
        r_at[r_wr_ptr]   <= upd_ataken;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
    end
  end

  always_comb begin
    bht_wr_valid  = w_nonempty;
    bht_wr_index  = r_idx[r_rd_ptr];
    bht_wr_hist   = r_hist[r_rd_ptr];
    bht_wr_misp   = r_misp[r_rd_ptr];
    bht_wr_ataken = r_at[r_rd_ptr];
    q_count       = r_count;
    q_full        = w_full;
    drop_pulse    = r_drop;
  end

`ifdef RV_BPUPD_STATS_EN
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_misp;
  logic [31:0] r_stat_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_upd  <= '0;
      r_stat_misp <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_coal | w_alloc) r_stat_upd <= r_stat_upd + 32'd1;
      if (w_push & upd_misp) r_stat_misp <= r_stat_misp + 32'd1;
      if (w_drop) r_stat_drop <= r_stat_drop + 32'd1;
    end
  end

  assign stat_upd  = r_stat_upd;
  assign stat_misp = r_stat_misp;
  assign stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_exu_bp_upd_q.sv
// Directed self-checking bench for exu_bp_upd_q (DEPTH=4, IDX_W=8).
module tb_exu_bp_upd_q;

  logic       clk;
  logic       rst;
  logic       freeze;
  logic       upd_valid;
  logic       upd_misp;
  logic       upd_ataken;
  logic [1:0] upd_hist;
  logic [7:0] upd_index;
  logic       bht_wr_valid;
  logic       bht_wr_ready;
  logic [7:0] bht_wr_index;
  logic [1:0] bht_wr_hist;
  logic       bht_wr_misp;
  logic       bht_wr_ataken;
  logic [2:0] q_count;
  logic       q_full;
  logic       drop_pulse;
`ifdef RV_BPUPD_STATS_EN
  logic [31:0] stat_upd;
  logic [31:0] stat_misp;
  logic [31:0] stat_drop;
`endif

  int checks = 0;
  int errors = 0;

  exu_bp_upd_q #(
    .DEPTH(4),
    .IDX_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .upd_valid    (upd_valid),
    .upd_misp     (upd_misp),
    .upd_ataken   (upd_ataken),
    .upd_hist     (upd_hist),
    .upd_index    (upd_index),
    .bht_wr_valid (bht_wr_valid),
    .bht_wr_ready (bht_wr_ready),
    .bht_wr_index (bht_wr_index),
    .bht_wr_hist  (bht_wr_hist),
    .bht_wr_misp  (bht_wr_misp),
    .bht_wr_ataken(bht_wr_ataken),
    .q_count      (q_count),
    .q_full       (q_full),
    .drop_pulse   (drop_pulse)
`ifdef RV_BPUPD_STATS_EN
    ,
    .stat_upd     (stat_upd),
    .stat_misp    (stat_misp),
    .stat_drop    (stat_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [7:0] idx, input logic [1:0] h,
                         input logic m, input logic t);
    upd_valid  = v;
    upd_index  = idx;
    upd_hist   = h;
    upd_misp   = m;
    upd_ataken = t;
  endtask

  task automatic do_reset();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    bht_wr_ready = 1'b0;
    freeze       = 1'b0;
    rst          = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    upd_valid = 1'b1; upd_index = 8'hAA; upd_hist = 2'b11; upd_misp = 1'b1; upd_ataken = 1'b1;
    freeze = 1'b0; bht_wr_ready = 1'b1; rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0 || q_full !== 1'b0 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: count=%0d valid=%b full=%b drop=%b required 0/0/0/0",
               q_count, bht_wr_valid, q_full, drop_pulse);
    end
    checks++;
    if ({bht_wr_index, bht_wr_hist, bht_wr_misp, bht_wr_ataken} !== 12'h000) begin
      errors++;
      $display("FAIL reset_head: idx=%h hist=%b misp=%b at=%b required zeros",
               bht_wr_index, bht_wr_hist, bht_wr_misp, bht_wr_ataken);
    end
    // Ready while empty has no effect.
    bht_wr_ready = 1'b1;
    cyc();
    bht_wr_ready = 1'b0;
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_empty: count=%0d valid=%b required 0/0", q_count, bht_wr_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 8'h10 + 8'(i), 2'(i), 1'(i), 1'(i + 1));
      cyc();
    end
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd4 || q_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: count=%0d full=%b required 4/1", q_count, q_full);
    end
    bht_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_idx = 8'h10 + 8'(i);
      checks++;
      if (bht_wr_valid !== 1'b1 || bht_wr_index !== exp_idx || bht_wr_hist !== 2'(i)
          || bht_wr_misp !== 1'(i) || bht_wr_ataken !== 1'(i + 1)) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b idx=%h hist=%b misp=%b at=%b required 1 %h %b %b %b",
                 i, bht_wr_valid, bht_wr_index, bht_wr_hist, bht_wr_misp, bht_wr_ataken,
                 exp_idx, 2'(i), 1'(i), 1'(i + 1));
      end
      cyc();
    end
    bht_wr_ready = 1'b0;
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0 || q_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count=%0d valid=%b full=%b required 0/0/0",
               q_count, bht_wr_valid, q_full);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    set_upd(1'b1, 8'h20, 2'b01, 1'b1, 1'b0);
    cyc();
    set_upd(1'b1, 8'h20, 2'b10, 1'b0, 1'b1);
    cyc();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd1 || bht_wr_index !== 8'h20 || bht_wr_hist !== 2'b10
        || bht_wr_misp !== 1'b1 || bht_wr_ataken !== 1'b1) begin
      errors++;
      $display("FAIL coalesce: count=%0d idx=%h hist=%b misp=%b at=%b required 1 20 10 1 1",
               q_count, bht_wr_index, bht_wr_hist, bht_wr_misp, bht_wr_ataken);
    end
    // Different index after a coalesce allocates a second entry.
    set_upd(1'b1, 8'h21, 2'b11, 1'b0, 1'b0);
    cyc();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd2 || bht_wr_index !== 8'h20) begin
      errors++;
      $display("FAIL coalesce_alloc: count=%0d idx=%h required 2 20", q_count, bht_wr_index);
    end
  endtask

  task automatic test_q1_pushpop();
    do_reset();
    set_upd(1'b1, 8'h70, 2'b11, 1'b1, 1'b1);
    cyc();
    set_upd(1'b1, 8'h70, 2'b00, 1'b0, 1'b0);
    bht_wr_ready = 1'b1;
    cyc();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    bht_wr_ready = 1'b0;
    checks++;
    if (q_count !== 3'd1 || bht_wr_index !== 8'h70 || bht_wr_hist !== 2'b00
        || bht_wr_misp !== 1'b0 || bht_wr_ataken !== 1'b0) begin
      errors++;
      $display("FAIL q1_pushpop: count=%0d idx=%h hist=%b misp=%b at=%b required 1 70 00 0 0",
               q_count, bht_wr_index, bht_wr_hist, bht_wr_misp, bht_wr_ataken);
    end
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [7:0] exp_idx [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 8'h30 + 8'(i), 2'b01, 1'b0, 1'b0);
      cyc();
    end
    set_upd(1'b1, 8'h55, 2'b11, 1'b1, 1'b1);
    cyc();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (drop_pulse !== 1'b1 || q_count !== 3'd4 || bht_wr_index !== 8'h30) begin
      errors++;
      $display("FAIL overflow: drop=%b count=%0d idx=%h required 1 4 30",
               drop_pulse, q_count, bht_wr_index);
    end
`ifdef RV_BPUPD_STATS_EN
    checks++;
    if (stat_drop !== 32'd1 || stat_upd !== 32'd4 || stat_misp !== 32'd1) begin
      errors++;
      $display("FAIL stats: drop=%0d upd=%0d misp=%0d required 1 4 1",
               stat_drop, stat_upd, stat_misp);
    end
`endif
    cyc();
    checks++;
    if (drop_pulse !== 1'b0 || q_count !== 3'd4) begin
      errors++;
      $display("FAIL drop_once: drop=%b count=%0d required 0 4", drop_pulse, q_count);
    end
    // Full queue with simultaneous push and pop.
    set_upd(1'b1, 8'h66, 2'b10, 1'b1, 1'b0);
    bht_wr_ready = 1'b1;
    cyc();
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd4 || q_full !== 1'b1 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d full=%b drop=%b required 4 1 0",
               q_count, q_full, drop_pulse);
    end
    exp_idx[0] = 8'h31; exp_idx[1] = 8'h32; exp_idx[2] = 8'h33; exp_idx[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bht_wr_index !== exp_idx[i]) begin
        errors++;
        $display("FAIL full_order_%0d: idx=%h required %h", i, bht_wr_index, exp_idx[i]);
      end
      if (i < 3) cyc();
    end
    checks++;
    if (bht_wr_hist !== 2'b10 || bht_wr_misp !== 1'b1 || q_count !== 3'd1) begin
      errors++;
      $display("FAIL head_66: hist=%b misp=%b count=%0d required 10 1 1",
               bht_wr_hist, bht_wr_misp, q_count);
    end
    cyc();
    bht_wr_ready = 1'b0;
  endtask

  task automatic test_freeze_reset();
    do_reset();
    freeze = 1'b1;
    set_upd(1'b1, 8'h44, 2'b11, 1'b1, 1'b1);
    cyc();
    cyc();
    freeze = 1'b0;
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL freeze: count=%0d valid=%b required 0 0", q_count, bht_wr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      set_upd(1'b1, 8'h40 + 8'(i), 2'b01, 1'b1, 1'b1);
      cyc();
    end
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (q_count !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset: count=%0d required 3", q_count);
    end
    rst = 1'b1;
    bht_wr_ready = 1'b1;
    cyc();
    rst = 1'b0;
    bht_wr_ready = 1'b0;
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0 || bht_wr_index !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%b idx=%h required 0 0 00",
               q_count, bht_wr_valid, bht_wr_index);
    end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    bht_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_upd(1'b1, 8'(i), 2'b01, 1'b0, 1'b0);
      if (i > 0) begin
        checks++;
        if (bht_wr_valid !== 1'b1 || bht_wr_index !== 8'(i - 1) || q_count !== 3'd1) begin
          errors++;
          $display("FAIL wrap_%0d: valid=%b idx=%h count=%0d required 1 %h 1",
                   i, bht_wr_valid, bht_wr_index, q_count, 8'(i - 1));
        end
      end
      cyc();
    end
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bht_wr_index !== 8'h09 || q_count !== 3'd1) begin
      errors++;
      $display("FAIL wrap_last: idx=%h count=%0d required 09 1", bht_wr_index, q_count);
    end
    cyc();
    bht_wr_ready = 1'b0;
    checks++;
    if (q_count !== 3'd0 || bht_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: count=%0d valid=%b required 0 0", q_count, bht_wr_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    bht_wr_ready = 1'b0;
    set_upd(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_fill_drain();
    test_coalesce();
    test_q1_pushpop();
    test_overflow_and_full_pushpop();
    test_freeze_reset();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
